sd_cmd_sequencer: RTL and testbench
===================================

# sd_cmd_sequencer

Sequences every transaction on the SD command line and shares it between two requesters: software-issued commands from the register file and automatic CMD12 (stop transmission) requests from the data path. It grants one requester at a time, hands a single command to the command serializer, then tracks the command through response reception, optional busy signalling on DAT0 and response timeout. It sits between the register/interrupt logic and the command serializer, and drives the command-inhibit status bit.

## Interface
- `TimeoutTicks`, default 64: SD clock ticks allowed between command end and response end before a timeout is declared. Must be ≥1.
- `BusyTimeoutTicks`, default 1024: SD clock ticks allowed in the busy-wait state. Must be ≥1.

- `clk_i` in 1: system clock; the single clock of the block.
- `rst_i` in 1: reset. Synchronous and active-high.
- `sd_clk_en_i` in 1: one-cycle pulse per SD clock rising edge.
- `sw_valid_i` in 1: software command request.
- `sw_ready_o` out 1: software command accepted when high together with `sw_valid_i`.
- `sw_index_i` in 6: software command index.
- `sw_arg_i` in 32: software command argument.
- `sw_rsp_type_i` in 2: software response type: 0 none, 1 R48, 2 R136, 3 R48 with busy.
- `acmd12_req_i` in 1: single-cycle pulse requesting auto CMD12.
- `issue_valid_o` out 1: command presented to the serializer.
- `issue_ready_i` in 1: serializer accepts the command.
- `issue_index_o` out 6: issued command index.
- `issue_arg_o` out 32: issued command argument.
- `issue_rsp_type_o` out 2: issued response type.
- `cmd_done_i` in 1: pulse when the serializer has sent the last command bit.
- `rsp_done_i` in 1: pulse when the serializer has received the full response.
- `dat0_i` in 1: DAT0 level; low means the card is busy.
- `inhibit_cmd_o` out 1: command line in use.
- `owner_o` out 1: 0 software, 1 auto CMD12; valid while `inhibit_cmd_o` is high.
- `sw_done_o` out 1: pulse when a software command completes.
- `acmd12_done_o` out 1: pulse when an auto CMD12 completes.
- `timeout_o` out 1: pulse on a response timeout or a busy timeout.

## Operation
- States:
  - IDLE: no command in flight.
  - ISSUE: command presented to the serializer.
  - SEND: command bits being transmitted.
  - WAIT_RSP: waiting for the response.
  - WAIT_BUSY: waiting for DAT0 to release.
  - DONE: completion cycle.
- Auto CMD12 arrival:
  - `acmd12_req_i` sets the `acmd12_pend` flag in any state.
  - Further pulses while the flag is set are merged into it.
  - The flag clears when the auto CMD12 is granted.
- Arbitration in IDLE: `acmd12_pend` takes fixed priority over software.
- Auto CMD12 grant:
  - Loads index 12, argument 0, response type 3.
  - Sets owner to 1 and moves to ISSUE.
- Software grant:
  - `sw_ready_o` = IDLE && !`acmd12_pend`, computed combinationally from registered state.
  - When `sw_valid_i` is high under that condition, the request is captured, owner is set to 0 and the FSM moves to ISSUE.
- ISSUE: `issue_*` outputs are held stable while `issue_valid_o` is high; `issue_valid_o` && `issue_ready_i` → SEND.
- SEND, on `cmd_done_i`:
  - Response type 0 → DONE.
  - Response type 1–3 → WAIT_RSP, with the tick counter cleared.
- WAIT_RSP:
  - Counter increments on `sd_clk_en_i`.
  - `rsp_done_i` → WAIT_BUSY if type 3, otherwise DONE.
  - Counter reaching `TimeoutTicks` with no `rsp_done_i` → pulse `timeout_o`, go to IDLE, no done pulse.
  - If `rsp_done_i` arrives in the same cycle the counter reaches the limit, `rsp_done_i` wins.
- WAIT_BUSY:
  - Counter is cleared on entry and increments on `sd_clk_en_i`.
  - The first `sd_clk_en_i` cycle with `dat0_i` = 1 → DONE.
  - Counter reaching `BusyTimeoutTicks` → pulse `timeout_o`, go to IDLE.
- DONE: one cycle; pulses `sw_done_o` or `acmd12_done_o` according to owner, then → IDLE.
- `inhibit_cmd_o` = state != IDLE.
- Unexpected pulses are ignored: `cmd_done_i` or `rsp_done_i` in any state other than the one that consumes it.
- Counter width is `$clog2(max(TimeoutTicks, BusyTimeoutTicks)+1)`. The counter saturates and never wraps.

## Timing
- Reset values:
  - State IDLE, `acmd12_pend` = 0, counter = 0.
  - All pulse outputs 0; `issue_valid_o` 0; `inhibit_cmd_o` 0; `owner_o` 0; `issue_*` data 0.
  - `sw_ready_o` becomes 1 in the first cycle after reset deasserts.
- Reset asserted mid-transaction: the FSM returns to IDLE on the next edge, the pending flag is dropped and no done pulse is emitted.
- Grant latency: accept edge → `issue_valid_o` high in the next cycle.
- Handshake latency: `issue_ready_i` handshake → SEND in the next cycle.
- `sw_done_o` / `acmd12_done_o` go high exactly one cycle after the completing event (`cmd_done_i`, `rsp_done_i` or the DAT0-released tick).
- Back-to-back commands: the earliest next grant is in the cycle after DONE, which is IDLE.
- An `acmd12_req_i` arriving in the same cycle as a software accept does not pre-empt that software command; it is served next.
- All outputs are registered except `sw_ready_o`.

## Structure
- Package `sd_cmd_seq_pkg`:
  - `rsp_type_e` (NONE, R48, R136, R48B).
  - `seq_state_e`.
  - `CMD12_INDEX` = 6'd12.
  - `CMD12_ARG` = 32'h0.
- Sub-module `sd_tick_counter`:
  - Clear input, enable input (`sd_clk_en_i`) and limit input.
  - `hit_o` output; saturating.
  - Shared by WAIT_RSP and WAIT_BUSY.

## Test plan
- Software command CMD8, arg 32'h1AA, type 1: `cmd_done_i` followed by `rsp_done_i` 40 ticks later → exactly one `sw_done_o`, no `timeout_o`, `inhibit_cmd_o` high from the cycle after accept through DONE.
- `sw_valid_i` and `acmd12_req_i` asserted together in IDLE:
  - Auto CMD12 issued first (index 12, arg 0, type 3), with `sw_ready_o` held 0.
  - The software command is accepted after `acmd12_done_o`.
- `acmd12_req_i` pulses twice during a software command in WAIT_RSP → exactly one CMD12 issued afterwards.
- Type 1 command with no `rsp_done_i` and `TimeoutTicks` = 64 → `timeout_o` pulses on the cycle after the 64th tick; no done pulse; state returns to IDLE.
- Boundary case: `rsp_done_i` on the same cycle as the 64th tick → `sw_done_o`, no `timeout_o`.
- Type 3 command with `dat0_i` low for 100 ticks after the response → done pulse on the first tick with `dat0_i` high; with `dat0_i` held low and `BusyTimeoutTicks` = 1024 → `timeout_o` instead.
- `rst_i` asserted during WAIT_BUSY with `acmd12_pend` set → IDLE, `acmd12_pend` = 0, no command issued after release.

Source files
------------

// File: rtl/sd_cmd_seq_pkg.sv
// Shared types and constants for the SD command-line sequencer.
//   rsp_type_e  : response kinds carried with every command
//   seq_state_e : sequencer FSM states
//   CMD12_*     : fixed fields of the automatic stop-transmission command
//   max_int     : compile-time helper for sizing the tick counter
package sd_cmd_seq_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    R48  = 2'd1,
    R136 = 2'd2,
    R48B = 2'd3
  } rsp_type_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    SEND      = 3'd2,
    WAIT_RSP  = 3'd3,
    WAIT_BUSY = 3'd4,
    DONE      = 3'd5
  } seq_state_e;

  localparam logic [5:0]  CMD12_INDEX = 6'd12;
  localparam logic [31:0] CMD12_ARG   = 32'h0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sd_tick_counter.sv
// Saturating SD-clock tick counter used for response and busy timeouts.
//   clk_i   : system clock
//   rst_i   : synchronous active-high reset
//   clr_i   : clear the count (wins over en_i)
//   en_i    : one-cycle SD clock tick
//   limit_i : tick count at which hit_o fires
//   hit_o   : high in the cycle whose tick brings the count to limit_i
//             (or whenever the count already sits at/above it)
module sd_tick_counter #(
  parameter int W = 7
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         hit_o
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_reg <= '0;
    end else if (en_i && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Look-ahead compare: the timeout decision is taken in the same cycle as
  // the limit-reaching tick, so the registered timeout pulse lands one
  // cycle after that tick.
  always_comb begin
    if (en_i) begin
      hit_o = (count_reg >= (limit_i - 1'b1));
    end else begin
      hit_o = (count_reg >= limit_i);
    end
  end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// SD command-line sequencer: arbitrates software commands against automatic
// CMD12 requests, presents one command to the serializer and follows it
// through response, optional DAT0 busy and timeouts.
//   Software side : sw_valid_i/sw_ready_o, sw_index_i, sw_arg_i, sw_rsp_type_i
//   Auto CMD12    : acmd12_req_i pulse
//   Serializer    : issue_valid_o/issue_ready_i, issue_index_o, issue_arg_o,
//                   issue_rsp_type_o, cmd_done_i, rsp_done_i
//   Card          : dat0_i (low = busy), sd_clk_en_i tick
//   Status        : inhibit_cmd_o, owner_o, sw_done_o, acmd12_done_o, timeout_o
module sd_cmd_sequencer
  import sd_cmd_seq_pkg::*;
#(
  parameter int TimeoutTicks     = 64,
  parameter int BusyTimeoutTicks = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sd_clk_en_i,
  input  logic        sw_valid_i,
  output logic        sw_ready_o,
  input  logic [5:0]  sw_index_i,
  input  logic [31:0] sw_arg_i,
  input  logic [1:0]  sw_rsp_type_i,
  input  logic        acmd12_req_i,
  output logic        issue_valid_o,
  input  logic        issue_ready_i,
  output logic [5:0]  issue_index_o,
  output logic [31:0] issue_arg_o,
  output logic [1:0]  issue_rsp_type_o,
  input  logic        cmd_done_i,
  input  logic        rsp_done_i,
  input  logic        dat0_i,
  output logic        inhibit_cmd_o,
  output logic        owner_o,
  output logic        sw_done_o,
  output logic        acmd12_done_o,
  output logic        timeout_o
);

  localparam int CNT_W = $clog2(max_int(TimeoutTicks, BusyTimeoutTicks) + 1);
  localparam logic [CNT_W-1:0] RSP_LIMIT  = CNT_W'(TimeoutTicks);
  localparam logic [CNT_W-1:0] BUSY_LIMIT = CNT_W'(BusyTimeoutTicks);

  seq_state_e  state_reg, state_next;
  logic        acmd12_pend_reg, acmd12_pend_next;
  logic        issue_valid_reg, issue_valid_next;
  logic [5:0]  issue_index_reg, issue_index_next;
  logic [31:0] issue_arg_reg, issue_arg_next;
  logic [1:0]  issue_rsp_type_reg, issue_rsp_type_next;
  logic        owner_reg, owner_next;
  logic        inhibit_reg, inhibit_next;
  logic        sw_done_reg, sw_done_next;
  logic        acmd12_done_reg, acmd12_done_next;
  logic        timeout_reg, timeout_next;

  logic             cnt_clr, cnt_en, cnt_hit;
  logic [CNT_W-1:0] cnt_limit;

  logic grant_ac, grant_sw, handshake, released, in_wait;

  assign grant_ac   = (state_reg == IDLE) && acmd12_pend_reg;
  assign sw_ready_o = (state_reg == IDLE) && !acmd12_pend_reg;
  assign grant_sw   = sw_ready_o && sw_valid_i;
  assign handshake  = issue_valid_reg && issue_ready_i;
  assign released   = sd_clk_en_i && dat0_i;
  assign in_wait    = (state_reg == WAIT_RSP) || (state_reg == WAIT_BUSY);

  sd_tick_counter #(.W(CNT_W)) u_tick_counter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .limit_i (cnt_limit),
    .hit_o   (cnt_hit)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a completion event always beats a same-cycle timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_ac || grant_sw) state_next = ISSUE;
      end
      ISSUE: begin
        if (handshake) state_next = SEND;
      end
      SEND: begin
        if (cmd_done_i) begin
          state_next = (rsp_type_e'(issue_rsp_type_reg) == NONE) ? DONE : WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (rsp_done_i) begin
          state_next = (rsp_type_e'(issue_rsp_type_reg) == R48B) ? WAIT_BUSY : DONE;
        end else if (cnt_hit) begin
          state_next = IDLE;
        end
      end
      WAIT_BUSY: begin
        if (released) begin
          state_next = DONE;
        end else if (cnt_hit) begin
          state_next = IDLE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    issue_index_next    = issue_index_reg;
    issue_arg_next      = issue_arg_reg;
    issue_rsp_type_next = issue_rsp_type_reg;
    owner_next          = owner_reg;
    issue_valid_next    = issue_valid_reg;
    // Requests merge into the flag; a same-cycle pulse survives a grant of
    // software and is served after it.
    acmd12_pend_next    = (acmd12_pend_reg || acmd12_req_i) && !grant_ac;

    if (grant_ac) begin
      issue_index_next    = CMD12_INDEX;
      issue_arg_next      = CMD12_ARG;
      issue_rsp_type_next = 2'(R48B);
      owner_next          = 1'b1;
      issue_valid_next    = 1'b1;
    end else if (grant_sw) begin
      issue_index_next    = sw_index_i;
      issue_arg_next      = sw_arg_i;
      issue_rsp_type_next = sw_rsp_type_i;
      owner_next          = 1'b0;
      issue_valid_next    = 1'b1;
    end else if (handshake) begin
      issue_valid_next    = 1'b0;
    end

    inhibit_next     = (state_next != IDLE);
    sw_done_next     = (state_next == DONE) && !owner_reg;
    acmd12_done_next = (state_next == DONE) && owner_reg;
    timeout_next     = in_wait && (state_next == IDLE);

    // Counter restarts on every entry into a wait state.
    cnt_clr   = ((state_next == WAIT_RSP) && (state_reg != WAIT_RSP)) ||
                ((state_next == WAIT_BUSY) && (state_reg != WAIT_BUSY));
    cnt_en    = sd_clk_en_i && in_wait;
    cnt_limit = (state_reg == WAIT_BUSY) ? BUSY_LIMIT : RSP_LIMIT;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acmd12_pend_reg    <= 1'b0;
      issue_valid_reg    <= 1'b0;
      issue_index_reg    <= '0;
      issue_arg_reg      <= '0;
      issue_rsp_type_reg <= '0;
      owner_reg          <= 1'b0;
      inhibit_reg        <= 1'b0;
      sw_done_reg        <= 1'b0;
      acmd12_done_reg    <= 1'b0;
      timeout_reg        <= 1'b0;
    end else begin
      acmd12_pend_reg    <= acmd12_pend_next;
      issue_valid_reg    <= issue_valid_next;
      issue_index_reg    <= issue_index_next;
      issue_arg_reg      <= issue_arg_next;
      issue_rsp_type_reg <= issue_rsp_type_next;
      owner_reg          <= owner_next;
      inhibit_reg        <= inhibit_next;
      sw_done_reg        <= sw_done_next;
      acmd12_done_reg    <= acmd12_done_next;
      timeout_reg        <= timeout_next;
    end
  end

  assign issue_valid_o    = issue_valid_reg;
  assign issue_index_o    = issue_index_reg;
  assign issue_arg_o      = issue_arg_reg;
  assign issue_rsp_type_o = issue_rsp_type_reg;
  assign owner_o          = owner_reg;
  assign inhibit_cmd_o    = inhibit_reg;
  assign sw_done_o        = sw_done_reg;
  assign acmd12_done_o    = acmd12_done_reg;
  assign timeout_o        = timeout_reg;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Bench for sd_cmd_sequencer: table of software commands plus hand-written
// arbitration, merge and reset sequences. Issued commands are checked
// against a scoreboard queue filled when stimulus is driven.
module tb_sd_cmd_sequencer;

  localparam int TO  = 64;
  localparam int BTO = 1024;

  logic        clk = 1'b0;
  logic        rst_i, sd_clk_en, sw_valid, acmd12_req, issue_ready;
  logic        cmd_done, rsp_done, dat0;
  logic [5:0]  sw_index;
  logic [31:0] sw_arg;
  logic [1:0]  sw_rsp_type;
  logic        sw_ready_o, issue_valid_o, inhibit_cmd_o, owner_o;
  logic        sw_done_o, acmd12_done_o, timeout_o;
  logic [5:0]  issue_index_o;
  logic [31:0] issue_arg_o;
  logic [1:0]  issue_rsp_type_o;

  always #5 clk = ~clk;

  sd_cmd_sequencer #(.TimeoutTicks(TO), .BusyTimeoutTicks(BTO)) dut (
    .clk_i(clk), .rst_i(rst_i), .sd_clk_en_i(sd_clk_en),
    .sw_valid_i(sw_valid), .sw_ready_o(sw_ready_o), .sw_index_i(sw_index),
    .sw_arg_i(sw_arg), .sw_rsp_type_i(sw_rsp_type), .acmd12_req_i(acmd12_req),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready),
    .issue_index_o(issue_index_o), .issue_arg_o(issue_arg_o),
    .issue_rsp_type_o(issue_rsp_type_o), .cmd_done_i(cmd_done),
    .rsp_done_i(rsp_done), .dat0_i(dat0), .inhibit_cmd_o(inhibit_cmd_o),
    .owner_o(owner_o), .sw_done_o(sw_done_o), .acmd12_done_o(acmd12_done_o),
    .timeout_o(timeout_o)
  );

  typedef struct { logic [5:0] idx; logic [31:0] arg; logic [1:0] rt; } cmd_t;
  typedef struct { cmd_t c; int rsp_ticks; int busy_ticks; int exp_done; int exp_to; } vec_t;

  cmd_t exp_q[$];
  int n_cmp = 0, n_err = 0;
  int n_sw_done = 0, n_ac_done = 0, n_to = 0, n_hs = 0, n_sw_acc = 0;
  logic last_hs = 1'b0, last_acc = 1'b0;

  function automatic cmd_t mk(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt);
    cmd_t c;
    c.idx = idx; c.arg = arg; c.rt = rt;
    return c;
  endfunction

  function automatic vec_t mkv(input cmd_t c, input int rsp, input int busy, input int ed, input int et);
    vec_t v;
    v.c = c; v.rsp_ticks = rsp; v.busy_ticks = busy; v.exp_done = ed; v.exp_to = et;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: capture pre-edge handshake/accept, advance, then observe.
  task automatic cyc();
    logic hs_pre, acc_pre;
    cmd_t seen, e;
    hs_pre  = issue_valid_o && issue_ready && !rst_i;
    acc_pre = sw_valid && sw_ready_o && !rst_i;
    seen    = mk(issue_index_o, issue_arg_o, issue_rsp_type_o);
    @(posedge clk);
    #1;
    cmd_done   = 1'b0;
    rsp_done   = 1'b0;
    acmd12_req = 1'b0;
    sd_clk_en  = ~sd_clk_en;
    last_hs    = hs_pre;
    last_acc   = acc_pre;
    if (acc_pre) n_sw_acc++;
    if (hs_pre) begin
      n_hs++;
      $display("issue: index=%0d arg=%h type=%0d", seen.idx, seen.arg, seen.rt);
      if (exp_q.size() == 0) begin
        check("issue_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("issue_index", seen.idx, e.idx);
        check("issue_arg", seen.arg, e.arg);
        check("issue_rsp_type", seen.rt, e.rt);
      end
    end
    if (sw_done_o)     begin n_sw_done++; $display("complete: software"); end
    if (acmd12_done_o) begin n_ac_done++; $display("complete: auto cmd12"); end
    if (timeout_o)     begin n_to++;      $display("timeout"); end
  endtask

  task automatic sw_accept(input cmd_t c);
    int budget;
    sw_valid = 1'b1; sw_index = c.idx; sw_arg = c.arg; sw_rsp_type = c.rt;
    exp_q.push_back(c);
    budget = 0;
    do begin cyc(); budget++; end while (!last_acc && budget < 3000);
    sw_valid = 1'b0;
    check("sw_accept_seen", last_acc, 1);
    check("inhibit_after_accept", inhibit_cmd_o, 1);
    check("owner_sw", owner_o, 0);
    check("issue_valid_after_accept", issue_valid_o, 1);
  endtask

  // Plays the serializer and card from ISSUE until the sequencer is idle.
  // ac_tick >= 0 : pulse acmd12_req at response ticks ac_tick and ac_tick+3.
  // rst_tick >= 0: pulse acmd12_req at busy tick 10, reset at busy rst_tick.
  task automatic serve(input logic [1:0] rt, input int rsp_ticks, input int busy_ticks,
                       input int ac_tick, input int rst_tick);
    int t, budget;
    logic got_rsp, rel, pushed, aborted;
    pushed = 1'b0; aborted = 1'b0; got_rsp = 1'b0; rel = 1'b0;
    budget = 0;
    do begin cyc(); budget++; end while (!last_hs && budget < 10);
    check("handshake_seen", last_hs, 1);
    repeat (3) cyc();
    cmd_done = 1'b1;
    cyc();
    if (rt == 2'd0) begin
      check("done_latency_cmd", sw_done_o | acmd12_done_o, 1);
    end else begin
      t = 0; budget = 0;
      while (budget < 4 * TO + 10) begin
        if (sd_clk_en) t++;
        if (ac_tick >= 0 && sd_clk_en && (t == ac_tick || t == ac_tick + 3)) begin
          acmd12_req = 1'b1;
          if (!pushed) exp_q.push_back(mk(6'd12, 32'h0, 2'd3));
          pushed = 1'b1;
        end
        if (rsp_ticks >= 0 && sd_clk_en && t == rsp_ticks) begin
          rsp_done = 1'b1;
          got_rsp = 1'b1;
        end
        cyc();
        budget++;
        if (got_rsp || timeout_o) break;
      end
      if (!got_rsp) begin
        check("rsp_timeout_seen", timeout_o, 1);
        check("rsp_timeout_tick", t, TO);
        check("idle_at_rsp_timeout", inhibit_cmd_o, 0);
      end else if (rt != 2'd3) begin
        check("done_latency_rsp", sw_done_o | acmd12_done_o, 1);
      end else begin
        t = 0; budget = 0; dat0 = 1'b0;
        while (budget < 3 * BTO + 10) begin
          if (sd_clk_en) t++;
          dat0 = (busy_ticks >= 0) && (t > busy_ticks);
          if (rst_tick >= 0 && sd_clk_en && t == 10) acmd12_req = 1'b1;
          if (rst_tick >= 0 && t == rst_tick) begin
            rst_i = 1'b1;
            cyc(); cyc();
            rst_i = 1'b0;
            aborted = 1'b1;
            break;
          end
          rel = sd_clk_en && dat0;
          cyc();
          budget++;
          if (rel || timeout_o) break;
        end
        if (!aborted) begin
          if (busy_ticks >= 0) begin
            check("done_latency_busy", sw_done_o | acmd12_done_o, 1);
            check("busy_release_tick", t, busy_ticks + 1);
          end else begin
            check("busy_timeout_seen", timeout_o, 1);
            check("busy_timeout_tick", t, BTO);
          end
        end
      end
    end
    dat0 = 1'b1;
    budget = 0;
    while (inhibit_cmd_o && budget < 8) begin cyc(); budget++; end
    check("back_to_idle", inhibit_cmd_o, 0);
  endtask

  vec_t vecs[8];
  int s0, a0, t0, h0, c0;

  initial begin
    rst_i = 1'b1; sd_clk_en = 1'b0; sw_valid = 1'b0; acmd12_req = 1'b0;
    issue_ready = 1'b1; cmd_done = 1'b0; rsp_done = 1'b0; dat0 = 1'b1;
    sw_index = '0; sw_arg = '0; sw_rsp_type = '0;

    vecs[0] = mkv(mk(6'd8,  32'h0000_01AA, 2'd1), 40, -1, 1, 0);
    vecs[1] = mkv(mk(6'd0,  32'h0,         2'd0), -1, -1, 1, 0);
    vecs[2] = mkv(mk(6'd2,  32'h0,         2'd2),  5, -1, 1, 0);
    vecs[3] = mkv(mk(6'd7,  32'h1234_0000, 2'd3),  3, 100, 1, 0);
    vecs[4] = mkv(mk(6'd13, 32'h1234_0000, 2'd1), -1, -1, 0, 1);
    vecs[5] = mkv(mk(6'd17, 32'hDEAD_BEEF, 2'd1), TO, -1, 1, 0);
    vecs[6] = mkv(mk(6'd6,  32'h03B7_0100, 2'd3),  2, -1, 0, 1);
    vecs[7] = mkv(mk(6'd55, 32'hA5A5_0000, 2'd1), TO - 1, -1, 1, 0);

    repeat (3) cyc();
    check("rst_inhibit", inhibit_cmd_o, 0);
    check("rst_issue_valid", issue_valid_o, 0);
    check("rst_owner", owner_o, 0);
    check("rst_issue_data", {issue_index_o, issue_arg_o, issue_rsp_type_o}, 0);
    check("rst_pulses", {sw_done_o, acmd12_done_o, timeout_o}, 0);
    rst_i = 1'b0;
    cyc();
    check("sw_ready_after_rst", sw_ready_o, 1);

    // Table-driven software commands
    for (int i = 0; i < 8; i++) begin
      s0 = n_sw_done; a0 = n_ac_done; t0 = n_to;
      sw_accept(vecs[i].c);
      serve(vecs[i].c.rt, vecs[i].rsp_ticks, vecs[i].busy_ticks, -1, -1);
      check("vec_sw_done", n_sw_done - s0, vecs[i].exp_done);
      check("vec_ac_done", n_ac_done - a0, 0);
      check("vec_timeout", n_to - t0, vecs[i].exp_to);
      check("vec_sw_ready", sw_ready_o, 1);
    end

    // Pending CMD12 blocks a software request and is issued first
    s0 = n_sw_done; a0 = n_ac_done; c0 = n_sw_acc;
    acmd12_req = 1'b1;
    exp_q.push_back(mk(6'd12, 32'h0, 2'd3));
    cyc();
    sw_valid = 1'b1; sw_index = 6'd16; sw_arg = 32'h200; sw_rsp_type = 2'd1;
    exp_q.push_back(mk(6'd16, 32'h200, 2'd1));
    check("sw_ready_blocked", sw_ready_o, 0);
    cyc();
    check("owner_ac", owner_o, 1);
    check("sw_ready_busy", sw_ready_o, 0);
    serve(2'd3, 2, 0, -1, -1);
    check("ac_first_done", n_ac_done - a0, 1);
    check("sw_not_accepted_early", n_sw_acc - c0, 0);
    cyc();
    check("sw_accept_after_ac", last_acc, 1);
    sw_valid = 1'b0;
    serve(2'd1, 5, -1, -1, -1);
    check("sw_after_ac_done", n_sw_done - s0, 1);

    // Same-cycle request: software accepted, CMD12 served right after
    s0 = n_sw_done; a0 = n_ac_done;
    sw_valid = 1'b1; sw_index = 6'd9; sw_arg = 32'h5555_0000; sw_rsp_type = 2'd2;
    acmd12_req = 1'b1;
    exp_q.push_back(mk(6'd9, 32'h5555_0000, 2'd2));
    exp_q.push_back(mk(6'd12, 32'h0, 2'd3));
    cyc();
    sw_valid = 1'b0;
    check("same_cycle_sw_wins", last_acc, 1);
    check("same_cycle_owner", owner_o, 0);
    serve(2'd2, 4, -1, -1, -1);
    cyc();
    check("cmd12_next_owner", owner_o, 1);
    check("cmd12_next_valid", issue_valid_o, 1);
    serve(2'd3, 2, 0, -1, -1);
    check("same_cycle_sw_done", n_sw_done - s0, 1);
    check("same_cycle_ac_done", n_ac_done - a0, 1);

    // Two CMD12 pulses during WAIT_RSP merge into one command
    h0 = n_hs; a0 = n_ac_done;
    sw_accept(mk(6'd18, 32'h0000_1000, 2'd1));
    serve(2'd1, 30, -1, 5, -1);
    cyc();
    serve(2'd3, 2, 0, -1, -1);
    repeat (10) cyc();
    check("merge_issue_count", n_hs - h0, 2);
    check("merge_ac_done", n_ac_done - a0, 1);

    // Reset in WAIT_BUSY with a pending CMD12 drops everything
    sw_accept(mk(6'd7, 32'h0001_0000, 2'd3));
    h0 = n_hs + 1; s0 = n_sw_done; a0 = n_ac_done;
    serve(2'd3, 2, -1, -1, 20);
    repeat (20) cyc();
    check("rst_mid_no_issue", n_hs, h0);
    check("rst_mid_no_done", (n_sw_done - s0) + (n_ac_done - a0), 0);
    check("rst_mid_idle", inhibit_cmd_o, 0);
    check("rst_mid_pend_dropped", sw_ready_o, 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
